issue_queue_select: RTL and testbench

//  Age-ordered issue queue feeding the register-read stage. Holds renamed ops

---
 rtl/pipe_fields_pkg.sv | 20 ++
 rtl/issq_pick.sv | 29 ++
 rtl/issue_queue_select.sv | 133 +++++++++++++
 tb/tb_issue_queue_select.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_fields_pkg.sv
// rtl/pipe_fields_pkg.sv - payload field offsets shared by the issue queue and register-read stage
// Purpose: single definition of the op payload layout carried from dispatch through issue.
// Contents: PAYLOAD_W and the bit offsets of the source tags/ready bits, ROB id and PC.
package pipe_fields_pkg;

    localparam int PAYLOAD_W   = 137;

    localparam int PC_LO       = 0;
    localparam int PC_HI       = 63;
    localparam int ROB_LO      = 64;
    localparam int ROB_HI      = 71;

    localparam int SRC1_TAG_LO = 76;
    localparam int SRC1_TAG_HI = 81;
    localparam int SRC1_RDY    = 82;
    localparam int SRC2_TAG_LO = 83;
    localparam int SRC2_TAG_HI = 88;
    localparam int SRC2_RDY    = 89;

endpackage

// File: rtl/issq_pick.sv
// rtl/issq_pick.sv - find-first-set picker, lowest index wins
// Purpose: chooses the oldest requesting slot of a compacting queue.
// Ports: req (N request bits), grant (one-hot), idx (encoded grant), any (some request set).
module issq_pick #(
    parameter int  N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue_select.sv
// rtl/issue_queue_select.sv - age-ordered issue queue with oldest-ready select
// Purpose: holds renamed ops, snoops writeback tags for source readiness and each
//  unfrozen cycle pops the oldest op with both sources ready onto the issue bus.
// Ports: CLK, RESET (async, active-low), FREEZE (hold issue, no select), FLUSH (squash),
//  enq_valid/enq_data/enq_ready (dispatch side), wb_valid/wb_tag (tag broadcast),
//  issue_valid/issue_data (registered issue bus), count (occupied entries).
// Option: ISSQ_WAKEUP_BYPASS_EN lets the current broadcast count toward readiness at select.
module issue_queue_select #(
    parameter int  DEPTH     = 8,
    parameter int  PAYLOAD_W = pipe_fields_pkg::PAYLOAD_W,
    parameter int  PREG_W    = 6,
    parameter bit  MEM_Q     = 1'b0,
    localparam int CNT_W     = $clog2(DEPTH) + 1,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FREEZE,
    input  logic                 FLUSH,
    input  logic                 enq_valid,
    input  logic [PAYLOAD_W-1:0] enq_data,
    output logic                 enq_ready,
    input  logic                 wb_valid,
    input  logic [PREG_W-1:0]    wb_tag,
    output logic                 issue_valid,
    output logic [PAYLOAD_W-1:0] issue_data,
    output logic [CNT_W-1:0]     count
);

    import pipe_fields_pkg::*;

    logic [PAYLOAD_W-1:0] slot_q  [DEPTH];
    logic [PAYLOAD_W-1:0] woken   [DEPTH];
    logic [PAYLOAD_W-1:0] shifted [DEPTH];
    logic [PAYLOAD_W-1:0] slot_d  [DEPTH];
    logic [PAYLOAD_W-1:0] enq_woken;
    logic [PAYLOAD_W-1:0] pick_data;
    logic [DEPTH-1:0]     req;
    logic [DEPTH-1:0]     grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 do_issue;
    logic                 do_enq;
    logic [CNT_W-1:0]     enq_slot;

    function automatic logic [PAYLOAD_W-1:0] apply_wakeup(
        input logic [PAYLOAD_W-1:0] p,
        input logic                 v,
        input logic [PREG_W-1:0]    tag
    );
        logic [PAYLOAD_W-1:0] r;
        r = p;
        if (v && p[SRC1_TAG_LO +: PREG_W] == tag) r[SRC1_RDY] = 1'b1;
        if (v && p[SRC2_TAG_LO +: PREG_W] == tag) r[SRC2_RDY] = 1'b1;
        return r;
    endfunction

    assign enq_ready = (count < CNT_W'(DEPTH));
    assign do_enq    = enq_valid && enq_ready;
    assign enq_woken = apply_wakeup(enq_data, wb_valid, wb_tag);

    always_comb begin
        req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = apply_wakeup(slot_q[i], wb_valid, wb_tag);
`ifdef ISSQ_WAKEUP_BYPASS_EN
            req[i] = (CNT_W'(i) < count) && woken[i][SRC1_RDY] && (woken[i][SRC2_RDY] || MEM_Q);
`else
            req[i] = (CNT_W'(i) < count) && slot_q[i][SRC1_RDY] && (slot_q[i][SRC2_RDY] || MEM_Q);
`endif
        end
    end

    issq_pick #(.N(DEPTH)) u_pick (
        .req   (req),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign do_issue = !FREEZE && !FLUSH && pick_any;

    // The issued payload always leaves with both ready bits set, whichever way it got ready.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) pick_data = pick_data | woken[i];
        end
        pick_data[SRC1_RDY] = 1'b1;
        pick_data[SRC2_RDY] = 1'b1;
    end

    // Compaction source: each slot's upper neighbour (top slot just repeats itself).
    for (genvar g = 0; g < DEPTH; g++) begin : g_shift
        if (g < DEPTH - 1) begin : g_up
            assign shifted[g] = woken[g+1];
        end else begin : g_top
            assign shifted[g] = woken[g];
        end
    end

    // Slots at or above the issued one shift down; the new op lands after compaction.
    always_comb begin
        enq_slot = count - CNT_W'(do_issue);
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = (do_issue && i >= int'(pick_idx)) ? shifted[i] : woken[i];
            if (do_enq && CNT_W'(i) == enq_slot) slot_d[i] = enq_woken;
        end
    end

    // Slot contents are qualified by count, so the payload array needs no reset.
    always_ff @(posedge CLK) begin
        slot_q <= slot_d;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count       <= '0;
            issue_valid <= 1'b0;
            issue_data  <= '0;
        end else if (FLUSH) begin
            count       <= '0;
            issue_valid <= 1'b0;
        end else begin
            count <= count + CNT_W'(do_enq) - CNT_W'(do_issue);
            if (!FREEZE) begin
                issue_valid <= pick_any;
                if (pick_any) issue_data <= pick_data;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_select.sv
// tb/tb_issue_queue_select.sv - self-checking bench for issue_queue_select
module tb_issue_queue_select;

    localparam int PW    = 137;
    localparam int DEPTH = 8;
`ifdef ISSQ_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          FREEZE;
    logic          FLUSH;
    logic          enq_valid;
    logic [PW-1:0] enq_data;
    logic          enq_ready;
    logic          wb_valid;
    logic [5:0]    wb_tag;
    logic          issue_valid;
    logic [PW-1:0] issue_data;
    logic [3:0]    count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] mq[$];
    logic          m_iv;
    logic [PW-1:0] m_id;

    issue_queue_select #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .PREG_W(6), .MEM_Q(1'b0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FREEZE      (FREEZE),
        .FLUSH       (FLUSH),
        .enq_valid   (enq_valid),
        .enq_data    (enq_data),
        .enq_ready   (enq_ready),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .issue_valid (issue_valid),
        .issue_data  (issue_data),
        .count       (count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] make_op(input logic [5:0] t1, input logic r1,
                                              input logic [5:0] t2, input logic r2,
                                              input logic [7:0] rob);
        logic [159:0] raw;
        logic [PW-1:0] p;
        raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        p = raw[PW-1:0];
        p[81:76] = t1;
        p[82]    = r1;
        p[88:83] = t2;
        p[89]    = r2;
        p[71:64] = rob;
        return p;
    endfunction

    function automatic logic [PW-1:0] wake(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        r = p;
        if (wb_valid && p[81:76] == wb_tag) r[82] = 1'b1;
        if (wb_valid && p[88:83] == wb_tag) r[89] = 1'b1;
        return r;
    endfunction

    // Queue-level reference: pop oldest ready, wake the rest, append the new op.
    task automatic model_step();
        bit            room;
        int            k;
        logic [PW-1:0] sel;
        if (FLUSH) begin
            mq.delete();
            m_iv = 1'b0;
        end else begin
            room = (mq.size() < DEPTH);
            if (!FREEZE) begin
                k = -1;
                foreach (mq[i]) begin
                    sel = BYP ? wake(mq[i]) : mq[i];
                    if (k < 0 && sel[82] && sel[89]) k = i;
                end
                if (k >= 0) begin
                    m_id = wake(mq[k]);
                    m_id[82] = 1'b1;
                    m_id[89] = 1'b1;
                    m_iv = 1'b1;
                    mq.delete(k);
                end else begin
                    m_iv = 1'b0;
                end
            end
            foreach (mq[i]) mq[i] = wake(mq[i]);
            if (enq_valid && room) mq.push_back(wake(enq_data));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("count", PW'(count), PW'(mq.size()));
        chk("enq_ready", PW'(enq_ready), PW'(mq.size() < DEPTH));
        chk("issue_valid", PW'(issue_valid), PW'(m_iv));
        chk("issue_data", issue_data, m_id);
    endtask

    task automatic idle();
        enq_valid = 1'b0;
        wb_valid  = 1'b0;
        FREEZE    = 1'b0;
        FLUSH     = 1'b0;
    endtask

    logic [PW-1:0] op_a;
    logic [PW-1:0] op_b;
    logic [7:0]    rob_n;

    initial begin
        RESET = 1'b0;
        enq_data = '0;
        wb_tag = '0;
        idle();
        mq.delete();
        m_iv = 1'b0;
        m_id = '0;

        // reset state
        @(posedge CLK);
        #1;
        chk("rst_count", PW'(count), '0);
        chk("rst_issue_valid", PW'(issue_valid), '0);
        chk("rst_issue_data", issue_data, '0);
        chk("rst_enq_ready", PW'(enq_ready), PW'(1));
        RESET = 1'b1;

        // older op A waits on tag 5, younger ready op B goes first
        op_a = make_op(6'd5, 1'b0, 6'd9, 1'b1, 8'hA0);
        op_b = make_op(6'd12, 1'b1, 6'd13, 1'b1, 8'hB0);
        enq_valid = 1'b1; enq_data = op_a; tick();
        enq_data = op_b; tick();
        idle(); tick();
        chk("b_first_rob", PW'(issue_data[71:64]), PW'(8'hB0));
        chk("a_stays_count", PW'(count), PW'(1));
        FLUSH = 1'b1; tick();
        idle();

        // wakeup one cycle after enqueue
        op_a = make_op(6'd5, 1'b0, 6'd7, 1'b1, 8'hA1);
        enq_valid = 1'b1; enq_data = op_a; tick();
        enq_valid = 1'b0; wb_valid = 1'b1; wb_tag = 6'd5; tick();
        chk("wake_edge_w_valid", PW'(issue_valid), PW'(BYP));
        idle(); tick();
        chk("wake_w1_rob", PW'(issue_data[71:64]), PW'(8'hA1));
        chk("wake_rdy82", PW'(issue_data[82]), PW'(1));

        // fill to full under FREEZE, then drain in order
        FREEZE = 1'b1; enq_valid = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            enq_data = make_op(6'(k), 1'b1, 6'(k + 8), 1'b1, 8'(k));
            tick();
        end
        enq_data = make_op(6'd1, 1'b1, 6'd2, 1'b1, 8'hEE); tick();
        chk("full_enq_ready", PW'(enq_ready), '0);
        chk("full_count", PW'(count), PW'(8));
        FREEZE = 1'b0; tick();
        chk("full_issue_no_enq", PW'(count), PW'(7));
        chk("drain_rob0", PW'(issue_data[71:64]), '0);
        enq_valid = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            tick();
            chk("drain_order", PW'(issue_data[71:64]), PW'(k));
        end
        tick();

        // FREEZE holds issue outputs and count
        FREEZE = 1'b1; enq_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            enq_data = make_op(6'd20, 1'b1, 6'd21, 1'b1, 8'(8'h30 + k));
            tick();
        end
        idle(); tick();
        FREEZE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("frz_count", PW'(count), PW'(2));
            chk("frz_rob", PW'(issue_data[71:64]), PW'(8'h30));
        end
        FREEZE = 1'b0; tick();
        chk("frz_resume1", PW'(issue_data[71:64]), PW'(8'h31));
        tick();
        chk("frz_resume2", PW'(issue_data[71:64]), PW'(8'h32));

        // FLUSH with concurrent enqueue and issue at count=4
        FREEZE = 1'b1; enq_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            enq_data = make_op(6'd30, 1'b1, 6'd31, 1'b1, 8'(8'h40 + k));
            tick();
        end
        FREEZE = 1'b0; FLUSH = 1'b1; enq_data = make_op(6'd1, 1'b1, 6'd1, 1'b1, 8'h4F); tick();
        chk("flush_count", PW'(count), '0);
        chk("flush_issue_valid", PW'(issue_valid), '0);
        idle(); tick();
        chk("flush_enq_lost", PW'(count), '0);

        // asynchronous reset mid-run
        FREEZE = 1'b1; enq_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            enq_data = make_op(6'd40, 1'b1, 6'd41, 1'b1, 8'(8'h50 + k));
            tick();
        end
        idle(); tick();
        chk("pre_rst_count", PW'(count), PW'(5));
        FREEZE = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
        chk("async_rst_count", PW'(count), '0);
        chk("async_rst_valid", PW'(issue_valid), '0);
        chk("async_rst_data", issue_data, '0);
        mq.delete();
        m_iv = 1'b0;
        m_id = '0;
        @(negedge CLK);
        RESET = 1'b1;
        idle();

        // randomized traffic against the reference model
        rob_n = 8'h60;
        for (int c = 0; c < 600; c++) begin
            enq_valid = ($urandom() % 4) != 0;
            enq_data  = make_op(6'($urandom() % 8), 1'($urandom() % 2),
                                6'($urandom() % 8), 1'($urandom() % 2), rob_n);
            rob_n     = rob_n + 8'd1;
            wb_valid  = ($urandom() % 2) != 0;
            wb_tag    = 6'($urandom() % 8);
            FREEZE    = ($urandom() % 5) == 0;
            FLUSH     = ($urandom() % 40) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
